apb_protocol_monitor: RTL and testbench
=======================================

Name: apb_protocol_monitor

Overview:
Synthesisable, parametrised APB slave-side protocol monitor; successor to the bench-only cover properties on the I2C APB interface.
- Sits passively on the APB bus in front of the I2C controller (or any APB peripheral). Drives no bus signals.
- Tracks each transfer with an FSM; checks phase ordering, control stability, PREADY timeout and per-register access direction.
- Exposes sticky error flags, an error pulse, transfer counters and the worst-case wait count for a status block or a bench scoreboard.

Parameters:
ADDR_W, 8, paddr width
DATA_W, 8, pwdata width
NREG, 8, number of mapped registers (addresses 0..NREG-1); NREG <= 2**ADDR_W
WO_MASK, 8'b0101_0100, bit i set = address i is write-only (default: 2, 4, 6)
RO_MASK, 8'b0010_1000, bit i set = address i is read-only (default: 3, 5)
TIMEOUT, 16, ACCESS cycles with pready=0 before a timeout is declared; minimum 2
CNT_W, 16, width of the transfer counters and wait_max

Ports:
pclk  in  1  APB clock
presetn  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB direction
paddr  in  ADDR_W  APB address
pwdata  in  DATA_W  APB write data
pready  in  1  slave ready
clr  in  1  synchronous clear of err_flags and all counters
err_flags  out  5  sticky error bits: [0] PHASE, [1] UNSTABLE, [2] TIMEOUT, [3] WR_TO_RO, [4] RD_FROM_WO
err_pulse  out  1  one-cycle pulse on any newly detected error
wr_count  out  CNT_W  completed write transfers, saturating
rd_count  out  CNT_W  completed read transfers, saturating
wait_max  out  CNT_W  largest wait-state count observed in a completed transfer
cov_hit  out  2*NREG  coverage bins (see Optional Feature)

Behaviour:
- Single clock pclk. presetn is asynchronous and active-low: asserting it forces state=IDLE and clears every output to 0, regardless of where a transfer is.
- All outputs are registered. Errors and counts update 1 cycle after the offending or completing pclk edge.
- FSM states:
  - IDLE:
    - psel & !penable -> SETUP; latch paddr, pwrite, pwdata.
    - psel & penable -> set PHASE; stay in IDLE.
  - SETUP (exactly one cycle):
    - psel & penable -> ACCESS; clear the wait counter.
    - Anything else -> set PHASE; go to IDLE.
    - Direction check in this cycle, only if paddr < NREG: WO_MASK[paddr] & !pwrite sets RD_FROM_WO; RO_MASK[paddr] & pwrite sets WR_TO_RO. Addresses >= NREG are never flagged.
  - ACCESS:
    - Any change of paddr or pwrite versus the latched values, or of pwdata on a write, sets UNSTABLE. It is set at most once per transfer.
    - psel or penable dropping before pready -> set PHASE; go to IDLE.
    - pready=1 -> transfer completes: increment wr_count or rd_count; wait_max = max(wait_max, wait counter); go to IDLE.
    - pready=0 -> wait counter +1. When it reaches TIMEOUT, set TIMEOUT, abandon the transfer (no count update), go to IDLE.
- After a completed transfer, the next cycle is evaluated by IDLE, so back-to-back transfers (SETUP immediately after completion) carry no penalty.
- A zero-wait transfer contributes 0 to wait_max.
- All counters saturate at all-ones and never wrap.
- err_flags bits are sticky. If clr coincides with a new error, the new error's bit remains set and err_pulse still fires. clr does not affect the FSM state.
- Multiple errors in one cycle set all their bits and produce a single err_pulse.

Optional Feature:
APB_MON_COVER_EN
- Defined:
  - cov_hit[i] is set sticky on a completed write to address i.
  - cov_hit[NREG+i] is set sticky on a completed read from address i.
  - Cleared by clr or reset.
- Undefined: cov_hit is tied to 0 and no coverage flops are inferred.

Decomposition:
- Package apb_mon_pkg:
  - state enum (IDLE, SETUP, ACCESS)
  - error bit index localparams (ERR_PHASE=0 .. ERR_RD_WO=4)
  - error vector width
- Sub-module apb_mon_sat_cnt: saturating counter (width param, inc, clr), instantiated for wr_count, rd_count and the wait counter.

Test Plan:
- Write to 2 with 0 waits, then read from 3 with 3 waits -> wr_count=1, rd_count=1, wait_max=3, err_flags=0.
- psel=1, penable=1 with no prior SETUP -> err_flags=5'b00001; err_pulse high for exactly 1 cycle.
- paddr changes 2->4 during ACCESS with 2 waits -> err_flags[1]=1; the transfer still completes and wr_count increments.
- pready held at 0 for 16 ACCESS cycles -> err_flags[2]=1 one cycle later; FSM in IDLE; counts unchanged.
- Read from 4 and write to 5 -> err_flags=5'b11000; then clr pulse -> all outputs 0. clr in the same cycle as a new PHASE error -> err_flags=5'b00001.
- With APB_MON_COVER_EN defined: writes to 0..7 -> cov_hit[7:0]=8'hFF, cov_hit[15:8]=0. Without it, cov_hit stays 0.

Source files
------------

// File: rtl/apb_mon_pkg.sv
// Shared types for the APB protocol monitor: FSM states and error bit indices.
package apb_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam int ERR_PHASE    = 0;
    localparam int ERR_UNSTABLE = 1;
    localparam int ERR_TIMEOUT  = 2;
    localparam int ERR_WR_RO    = 3;
    localparam int ERR_RD_WO    = 4;
    localparam int ERR_W        = 5;

endpackage

// File: rtl/apb_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module apb_mon_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB slave-side protocol monitor with sticky errors and counters.
// Define APB_MON_COVER_EN to build the per-register coverage bins.
module apb_protocol_monitor
    import apb_mon_pkg::*;
#(
    parameter int              ADDR_W  = 8,
    parameter int              DATA_W  = 8,
    parameter int              NREG    = 8,
    parameter logic [NREG-1:0] WO_MASK = NREG'(8'b0101_0100),
    parameter logic [NREG-1:0] RO_MASK = NREG'(8'b0010_1000),
    parameter int              TIMEOUT = 16,
    parameter int              CNT_W   = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              clr,
    output logic [ERR_W-1:0]  err_flags,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wait_max,
    output logic [2*NREG-1:0] cov_hit
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic              unst_q, unst_d;
    logic [ERR_W-1:0]  flags_q, flags_d;
    logic              pulse_q;
    logic [CNT_W-1:0]  wmax_q, wmax_d;
    logic [CNT_W-1:0]  wait_cnt;

    logic [ERR_W-1:0]  err_new;
    logic              latch, wait_clr, wait_inc;
    logic              done_wr, done_rd;
    logic              wo_hit, ro_hit, chg;

    // Addresses outside 0..NREG-1 never match, so they are never flagged.
    always_comb begin
        wo_hit = 1'b0;
        ro_hit = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (paddr == ADDR_W'(i)) begin
                wo_hit = WO_MASK[i];
                ro_hit = RO_MASK[i];
            end
        end
    end

    assign chg = (paddr != addr_q) || (pwrite != write_q) ||
                 (write_q && (pwdata != wdata_q));

    always_comb begin
        state_d  = state_q;
        unst_d   = unst_q;
        err_new  = '0;
        latch    = 1'b0;
        wait_clr = 1'b0;
        wait_inc = 1'b0;
        done_wr  = 1'b0;
        done_rd  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = SETUP;
                    latch   = 1'b1;
                end else if (psel && penable) begin
                    err_new[ERR_PHASE] = 1'b1;
                end
            end
            SETUP: begin
                if (psel && penable) begin
                    state_d  = ACCESS;
                    wait_clr = 1'b1;
                    unst_d   = 1'b0;
                end else begin
                    state_d            = IDLE;
                    err_new[ERR_PHASE] = 1'b1;
                end
                err_new[ERR_RD_WO] = wo_hit && !pwrite;
                err_new[ERR_WR_RO] = ro_hit && pwrite;
            end
            ACCESS: begin
                if (chg && !unst_q) begin
                    err_new[ERR_UNSTABLE] = 1'b1;
                    unst_d                = 1'b1;
                end
                if (!(psel && penable)) begin
                    state_d            = IDLE;
                    err_new[ERR_PHASE] = 1'b1;
                end else if (pready) begin
                    state_d = IDLE;
                    done_wr = write_q;
                    done_rd = !write_q;
                end else begin
                    wait_inc = 1'b1;
                    // This wait cycle is the TIMEOUT-th one.
                    if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state_d              = IDLE;
                        err_new[ERR_TIMEOUT] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flags_d = (clr ? '0 : flags_q) | err_new;
        wmax_d  = wmax_q;
        if (clr) begin
            wmax_d = '0;
        end else if ((done_wr || done_rd) && (wait_cnt > wmax_q)) begin
            wmax_d = wait_cnt;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            unst_q  <= 1'b0;
            flags_q <= '0;
            pulse_q <= 1'b0;
            wmax_q  <= '0;
        end else begin
            state_q <= state_d;
            unst_q  <= unst_d;
            flags_q <= flags_d;
            pulse_q <= |err_new;
            wmax_q  <= wmax_d;
            if (latch) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
            end
        end
    end

    apb_mon_sat_cnt #(.W(CNT_W)) u_wr_cnt (
        .clk_i  (pclk),
        .rst_ni (presetn),
        .clr_i  (clr),
        .inc_i  (done_wr),
        .cnt_o  (wr_count)
    );

    apb_mon_sat_cnt #(.W(CNT_W)) u_rd_cnt (
        .clk_i  (pclk),
        .rst_ni (presetn),
        .clr_i  (clr),
        .inc_i  (done_rd),
        .cnt_o  (rd_count)
    );

    apb_mon_sat_cnt #(.W(CNT_W)) u_wait_cnt (
        .clk_i  (pclk),
        .rst_ni (presetn),
        .clr_i  (wait_clr),
        .inc_i  (wait_inc),
        .cnt_o  (wait_cnt)
    );

`ifdef APB_MON_COVER_EN
    logic [NREG-1:0]   addr_sel;
    logic [2*NREG-1:0] cov_q, cov_d;

    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                addr_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cov_d = (clr ? '0 : cov_q) |
                {addr_sel & {NREG{done_rd}}, addr_sel & {NREG{done_wr}}};
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cov_q <= '0;
        end else begin
            cov_q <= cov_d;
        end
    end

    assign cov_hit = cov_q;
`else
    assign cov_hit = '0;
`endif

    assign err_flags = flags_q;
    assign err_pulse = pulse_q;
    assign wait_max  = wmax_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Directed self-checking bench for apb_protocol_monitor.
module tb_apb_protocol_monitor;

    logic        pclk;
    logic        presetn;
    logic        psel, penable, pwrite, pready, clr;
    logic [7:0]  paddr, pwdata;
    logic [4:0]  err_flags;
    logic        err_pulse;
    logic [15:0] wr_count, rd_count, wait_max;
    logic [15:0] cov_hit;
    logic [15:0] cov_exp;

    int n_chk = 0;
    int n_err = 0;

    apb_protocol_monitor dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .clr       (clr),
        .err_flags (err_flags),
        .err_pulse (err_pulse),
        .wr_count  (wr_count),
        .rd_count  (rd_count),
        .wait_max  (wait_max),
        .cov_hit   (cov_hit)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic bus_idle();
        psel    = 1'b0;
        penable = 1'b0;
        pready  = 1'b0;
    endtask

    task automatic setup(input logic [7:0] a, input logic w,
                         input logic [7:0] d);
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        pready  = 1'b0;
        tick();
        penable = 1'b1;
        tick();
    endtask

    task automatic xfer(input logic [7:0] a, input logic w,
                        input logic [7:0] d, input int waits);
        setup(a, w, d);
        for (int i = 0; i < waits; i++) begin
            pready = 1'b0;
            tick();
        end
        pready = 1'b1;
        tick();
        bus_idle();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        presetn = 1'b0;
        clr     = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pwrite  = 1'b0;
        bus_idle();
        repeat (2) tick();
        check("rst_flags", err_flags, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_wr", wr_count, 0);
        check("rst_rd", rd_count, 0);
        check("rst_wmax", wait_max, 0);
        check("rst_cov", cov_hit, 0);
        presetn = 1'b1;
        tick();

        xfer(8'd2, 1'b1, 8'hAA, 0);
        check("t1_wr", wr_count, 1);
        check("t1_wmax_zero", wait_max, 0);
        xfer(8'd3, 1'b0, 8'h00, 3);
        check("t1_rd", rd_count, 1);
        check("t1_wmax", wait_max, 3);
        check("t1_flags", err_flags, 0);

        check("t2_pulse_pre", err_pulse, 0);
        psel    = 1'b1;
        penable = 1'b1;
        tick();
        check("t2_flags", err_flags, 5'b00001);
        check("t2_pulse", err_pulse, 1);
        bus_idle();
        tick();
        check("t2_pulse_end", err_pulse, 0);
        check("t2_sticky", err_flags, 5'b00001);
        pulse_clr();
        check("t2_clr_flags", err_flags, 0);
        check("t2_clr_wr", wr_count, 0);
        check("t2_clr_rd", rd_count, 0);
        check("t2_clr_wmax", wait_max, 0);

        psel    = 1'b1;
        penable = 1'b0;
        paddr   = 8'd0;
        pwrite  = 1'b0;
        tick();
        psel = 1'b0;
        tick();
        check("t2b_setup_phase", err_flags, 5'b00001);
        pulse_clr();

        setup(8'd2, 1'b1, 8'h55);
        paddr  = 8'd4;
        pready = 1'b0;
        tick();
        check("t3_unst", err_flags, 5'b00010);
        check("t3_pulse", err_pulse, 1);
        tick();
        check("t3_once", err_pulse, 0);
        pready = 1'b1;
        tick();
        bus_idle();
        check("t3_wr", wr_count, 1);
        check("t3_wmax", wait_max, 2);

        setup(8'd0, 1'b0, 8'h00);
        pready = 1'b0;
        repeat (15) tick();
        check("t4_no_to_yet", err_flags, 5'b00010);
        tick();
        check("t4_to", err_flags, 5'b00110);
        check("t4_to_pulse", err_pulse, 1);
        bus_idle();
        tick();
        check("t4_idle", err_flags, 5'b00110);
        check("t4_rd", rd_count, 0);
        check("t4_wr", wr_count, 1);
        check("t4_wmax", wait_max, 2);
        xfer(8'd0, 1'b0, 8'h00, 0);
        check("t4_after_rd", rd_count, 1);
        check("t4_after_flags", err_flags, 5'b00110);

        pulse_clr();
        xfer(8'd4, 1'b0, 8'h00, 0);
        check("t5_rd_wo", err_flags, 5'b10000);
        xfer(8'd5, 1'b1, 8'h11, 0);
        check("t5_wr_ro", err_flags, 5'b11000);
        xfer(8'd12, 1'b0, 8'h00, 0);
        check("t5_oor", err_flags, 5'b11000);
        check("t5_rd", rd_count, 2);
        check("t5_wr", wr_count, 1);
        pulse_clr();
        check("t5_clr_flags", err_flags, 0);
        check("t5_clr_pulse", err_pulse, 0);
        check("t5_clr_wr", wr_count, 0);
        check("t5_clr_rd", rd_count, 0);
        check("t5_clr_cov", cov_hit, 0);
        clr     = 1'b1;
        psel    = 1'b1;
        penable = 1'b1;
        tick();
        clr = 1'b0;
        bus_idle();
        check("t5_clr_err", err_flags, 5'b00001);
        check("t5_clr_err_pulse", err_pulse, 1);
        pulse_clr();

        for (int i = 0; i < 8; i++) begin
            xfer(8'(i), 1'b1, 8'(i), 0);
        end
        xfer(8'd1, 1'b0, 8'h00, 0);
`ifdef APB_MON_COVER_EN
        cov_exp = 16'h02FF;
`else
        cov_exp = 16'h0000;
`endif
        check("t6_cov", cov_hit, cov_exp);
        check("t6_wr", wr_count, 8);
        check("t6_flags", err_flags, 5'b01000);

        setup(8'd2, 1'b1, 8'h00);
        #2;
        presetn = 1'b0;
        #1;
        check("t7_rst_flags", err_flags, 0);
        check("t7_rst_wr", wr_count, 0);
        check("t7_rst_cov", cov_hit, 0);
        bus_idle();
        tick();
        presetn = 1'b1;
        tick();
        xfer(8'd2, 1'b1, 8'h00, 1);
        check("t7_wr", wr_count, 1);
        check("t7_wmax", wait_max, 1);
        check("t7_flags", err_flags, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
